pp_align_array: RTL and testbench

- Exponent-alignment stage of the SD4 MAC datapath.
- Takes the nine sign-magnitude partial products from the partial-product generators, their per-lane exponents, and the group maximum exponent.
- Right-shifts each magnitude by (exp_max - exp) and converts it to 16-bit two's complement for the adder tree.
- Outputs are registered, one pipeline stage.

---
 rtl/pp_align_array.sv | 86 ++++++++
 tb/tb_pp_align_array.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_align_array.sv
// rtl/pp_align_array.sv - exponent alignment of SD4 partial products to 16-bit two's complement; ALIGN_STICKY_EN adds the sticky port
module pp_align_array #(
  parameter int LANES = 9,
  parameter int EXP_W = 5,
  parameter int PP_W  = 5,
  parameter int OUT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [EXP_W-1:0]       exp_max,
  input  logic [LANES*EXP_W-1:0] exp_all,
  input  logic [LANES*PP_W-1:0]  pp_all,
  output logic                   out_valid,
  output logic [EXP_W-1:0]       exp_max_out,
  output logic [LANES*OUT_W-1:0] aligned_all,
  output logic [LANES-1:0]       exp_err
`ifdef ALIGN_STICKY_EN
  ,
  output logic [LANES-1:0]       sticky
`endif
);

  localparam int MAG_W  = PP_W - 1;
  localparam int BASE_W = OUT_W - 1;
  localparam logic [BASE_W-1:0] ONES = '1;

  logic [LANES*OUT_W-1:0] aligned_nxt;
  logic [LANES-1:0]       err_nxt;
`ifdef ALIGN_STICKY_EN
  logic [LANES-1:0]       sticky_nxt;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    // Lane 0 occupies the most significant slice of every packed bus.
    localparam int L = LANES - 1 - g;

    logic [EXP_W-1:0]  lane_exp;
    logic [PP_W-1:0]   lane_pp;
    logic              lane_err;
    logic [EXP_W-1:0]  lane_shift;
    logic [BASE_W-1:0] lane_base;
    logic [BASE_W-1:0] lane_amag;

    assign lane_exp   = exp_all[L*EXP_W +: EXP_W];
    assign lane_pp    = pp_all[L*PP_W +: PP_W];
    assign lane_err   = lane_exp > exp_max;
    assign lane_shift = lane_err ? '0 : exp_max - lane_exp;
    assign lane_base  = {lane_pp[MAG_W-1:0], {(BASE_W-MAG_W){1'b0}}};
    // Shifts of BASE_W or more drain the magnitude to zero naturally.
    assign lane_amag  = lane_base >> lane_shift;

    assign aligned_nxt[L*OUT_W +: OUT_W] = lane_pp[PP_W-1] ? -{1'b0, lane_amag}
                                                           :  {1'b0, lane_amag};
    assign err_nxt[L] = lane_err;

`ifdef ALIGN_STICKY_EN
    logic [BASE_W-1:0] lane_keep;
    assign lane_keep     = ONES << lane_shift;
    assign sticky_nxt[L] = |(lane_base & ~lane_keep);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      exp_max_out <= '0;
      aligned_all <= '0;
      exp_err     <= '0;
`ifdef ALIGN_STICKY_EN
      sticky      <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        exp_max_out <= exp_max;
        aligned_all <= aligned_nxt;
        exp_err     <= err_nxt;
`ifdef ALIGN_STICKY_EN
        sticky      <= sticky_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pp_align_array.sv
// tb/tb_pp_align_array.sv - self-checking bench for pp_align_array against an arithmetic reference model
module tb_pp_align_array;

  localparam int LANES = 9;
  localparam int EXP_W = 5;
  localparam int PP_W  = 5;
  localparam int OUT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid = 1'b0;
  logic [EXP_W-1:0]       exp_max = '0;
  logic [LANES*EXP_W-1:0] exp_all = '0;
  logic [LANES*PP_W-1:0]  pp_all = '0;
  logic                   out_valid;
  logic [EXP_W-1:0]       exp_max_out;
  logic [LANES*OUT_W-1:0] aligned_all;
  logic [LANES-1:0]       exp_err;
  logic [LANES-1:0]       sticky_obs;

  int n_cmp = 0;
  int n_fail = 0;

  pp_align_array #(.LANES(LANES), .EXP_W(EXP_W), .PP_W(PP_W), .OUT_W(OUT_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .exp_max(exp_max),
    .exp_all(exp_all),
    .pp_all(pp_all),
    .out_valid(out_valid),
    .exp_max_out(exp_max_out),
    .aligned_all(aligned_all),
    .exp_err(exp_err)
`ifdef ALIGN_STICKY_EN
    ,
    .sticky(sticky_obs)
`endif
  );

`ifndef ALIGN_STICKY_EN
  assign sticky_obs = '0;
`endif

  always #5 clk = ~clk;

  function automatic int lane_shift(input int e, input int em);
    return (e > em) ? 0 : em - e;
  endfunction

  function automatic logic [LANES*OUT_W-1:0] ref_aligned(input logic [LANES*EXP_W-1:0] ea,
                                                         input logic [LANES*PP_W-1:0] pa,
                                                         input logic [EXP_W-1:0] em);
    logic [LANES*OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      int e, p, mag, sh, amag, v;
      e    = int'(ea[(LANES-1-i)*EXP_W +: EXP_W]);
      p    = int'(pa[(LANES-1-i)*PP_W +: PP_W]);
      mag  = p % 16;
      sh   = lane_shift(e, int'(em));
      amag = (sh >= 15) ? 0 : (mag * 2048) / (1 << sh);
      v    = (p >= 16) ? (65536 - amag) % 65536 : amag;
      r[(LANES-1-i)*OUT_W +: OUT_W] = 16'(v);
    end
    return r;
  endfunction

  function automatic logic [LANES-1:0] ref_err(input logic [LANES*EXP_W-1:0] ea,
                                               input logic [EXP_W-1:0] em);
    logic [LANES-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[LANES-1-i] = int'(ea[(LANES-1-i)*EXP_W +: EXP_W]) > int'(em);
    return r;
  endfunction

  function automatic logic [LANES-1:0] ref_sticky(input logic [LANES*EXP_W-1:0] ea,
                                                  input logic [LANES*PP_W-1:0] pa,
                                                  input logic [EXP_W-1:0] em);
    logic [LANES-1:0] r;
    r = '0;
`ifdef ALIGN_STICKY_EN
    for (int i = 0; i < LANES; i++) begin
      int mag, sh;
      mag = int'(pa[(LANES-1-i)*PP_W +: PP_W]) % 16;
      sh  = lane_shift(int'(ea[(LANES-1-i)*EXP_W +: EXP_W]), int'(em));
      r[LANES-1-i] = (sh >= 15) ? (mag != 0) : (((mag * 2048) % (1 << sh)) != 0);
    end
`endif
    return r;
  endfunction

  task automatic drive(input logic v, input logic [EXP_W-1:0] em,
                       input logic [LANES*EXP_W-1:0] ea, input logic [LANES*PP_W-1:0] pa);
    in_valid = v;
    exp_max  = em;
    exp_all  = ea;
    pp_all   = pa;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, exp_max_out, aligned_all, exp_err, sticky_obs} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b em=%0d al=%h err=%b st=%b, want all zero",
               out_valid, exp_max_out, aligned_all, exp_err, sticky_obs);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    int t_e[9]    = '{10, 10, 10, 7, 0, 0, 0, 0, 12};
    int t_em[9]   = '{10, 10, 10, 10, 12, 12, 15, 31, 10};
    int t_pp[9]   = '{5, 21, 16, 15, 15, 31, 15, 15, 3};
    int t_al[9]   = '{'h2800, 'hD800, 'h0000, 'h0F00, 'h0007, 'hFFF9, 'h0000, 'h0000, 'h1800};
    int t_st[9]   = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int t_err[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 9; k++) begin
      logic [LANES*EXP_W-1:0] ea;
      logic [LANES*PP_W-1:0]  pa;
      logic [EXP_W-1:0]       em;
      logic [OUT_W-1:0]       want_al;
      em = EXP_W'(t_em[k]);
      ea = '0;
      pa = LANES*PP_W'({$urandom, $urandom});
      ea[(LANES-1)*EXP_W +: EXP_W] = EXP_W'(t_e[k]);
      pa[(LANES-1)*PP_W +: PP_W]   = PP_W'(t_pp[k]);
      want_al = OUT_W'(t_al[k]);
      drive(1'b1, em, ea, pa);
      n_cmp++;
      if (aligned_all[(LANES-1)*OUT_W +: OUT_W] !== want_al || out_valid !== 1'b1 || exp_max_out !== em) begin
        n_fail++;
        $display("FAIL dir%0d_lane0: got al=%h ov=%b em=%0d, want al=%h ov=1 em=%0d",
                 k, aligned_all[(LANES-1)*OUT_W +: OUT_W], out_valid, exp_max_out, want_al, em);
      end
      n_cmp++;
      if (exp_err !== {(t_err[k] != 0), 8'b0}) begin
        n_fail++;
        $display("FAIL dir%0d_exp_err: got %b, want %b", k, exp_err, {(t_err[k] != 0), 8'b0});
      end
`ifdef ALIGN_STICKY_EN
      n_cmp++;
      if (sticky_obs[LANES-1] !== (t_st[k] != 0)) begin
        n_fail++;
        $display("FAIL dir%0d_sticky: got %b, want %b", k, sticky_obs[LANES-1], t_st[k] != 0);
      end
`endif
      n_cmp++;
      if (aligned_all !== ref_aligned(ea, pa, em)) begin
        n_fail++;
        $display("FAIL dir%0d_all_lanes: got %h, want %h", k, aligned_all, ref_aligned(ea, pa, em));
      end
    end
  endtask

  task automatic test_random();
    logic [LANES*OUT_W-1:0] want_al = aligned_all;
    logic [LANES-1:0]       want_err = exp_err;
    logic [LANES-1:0]       want_st = sticky_obs;
    logic [EXP_W-1:0]       want_em = exp_max_out;
    for (int k = 0; k < 60; k++) begin
      logic                   v;
      logic [EXP_W-1:0]       em;
      logic [LANES*EXP_W-1:0] ea;
      logic [LANES*PP_W-1:0]  pa;
      v  = ($urandom_range(3) != 0);
      em = EXP_W'($urandom);
      ea = LANES*EXP_W'({$urandom, $urandom});
      pa = LANES*PP_W'({$urandom, $urandom});
      if (v) begin
        want_al  = ref_aligned(ea, pa, em);
        want_err = ref_err(ea, em);
        want_st  = ref_sticky(ea, pa, em);
        want_em  = em;
      end
      drive(v, em, ea, pa);
      n_cmp++;
      if (out_valid !== v || aligned_all !== want_al || exp_err !== want_err ||
          sticky_obs !== want_st || exp_max_out !== want_em) begin
        n_fail++;
        $display("FAIL rand%0d: got ov=%b al=%h err=%b st=%b em=%0d, want ov=%b al=%h err=%b st=%b em=%0d",
                 k, out_valid, aligned_all, exp_err, sticky_obs, exp_max_out,
                 v, want_al, want_err, want_st, want_em);
      end
    end
  endtask

  task automatic test_hold();
    logic [LANES*EXP_W-1:0] ea = LANES*EXP_W'({$urandom, $urandom});
    logic [LANES*PP_W-1:0]  pa = LANES*PP_W'({$urandom, $urandom});
    logic [LANES*OUT_W-1:0] want = ref_aligned(ea, pa, 5'd9);
    for (int k = 0; k < 3; k++) begin
      drive(k == 0, EXP_W'(9 + 5 * k), ea, pa ^ LANES*PP_W'(k * 'h1234567));
      n_cmp++;
      if (out_valid !== (k == 0) || aligned_all !== want || exp_max_out !== 5'd9) begin
        n_fail++;
        $display("FAIL hold%0d: got ov=%b al=%h em=%0d, want ov=%b al=%h em=9",
                 k, out_valid, aligned_all, exp_max_out, k == 0, want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [LANES*EXP_W-1:0] ea = '0;
    logic [LANES*PP_W-1:0]  pa = {LANES{5'b00111}};
    drive(1'b1, 5'd3, ea, pa);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got ov=%b, want 1", out_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, exp_max_out, aligned_all, exp_err, sticky_obs} !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate: got ov=%b em=%0d al=%h err=%b, want all zero",
               out_valid, exp_max_out, aligned_all, exp_err);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, aligned_all} !== '0) begin
      n_fail++;
      $display("FAIL arst_held: got ov=%b al=%h, want zero", out_valid, aligned_all);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd3, ea, pa);
    n_cmp++;
    if (out_valid !== 1'b0 || aligned_all !== '0) begin
      n_fail++;
      $display("FAIL arst_release_idle: got ov=%b al=%h, want ov=0 al=0", out_valid, aligned_all);
    end
    drive(1'b1, 5'd3, ea, pa);
    n_cmp++;
    if (out_valid !== 1'b1 || aligned_all !== ref_aligned(ea, pa, 5'd3)) begin
      n_fail++;
      $display("FAIL arst_first_out: got ov=%b al=%h, want ov=1 al=%h",
               out_valid, aligned_all, ref_aligned(ea, pa, 5'd3));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
